hit_scorer: RTL and testbench

- Scoring stage of the whack-a-mole datapath. Sits directly downstream of the per-hole button register flip-flops.
- Consumes their registered button levels and the current mole position from the mole generator.
- Detects new presses and classifies each as a hit or a miss. Keeps a saturating BCD score and a miss count.
- Runs the IDLE/PLAY/OVER game-state machine that feeds the display and LED stages.

---
 rtl/hit_scorer_if.sv | 29 ++
 rtl/hit_scorer.sv | 127 ++++++++++++
 tb/tb_hit_scorer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hit_scorer_if.sv
// Player-side and display-side signals of the whack-a-mole scoring stage.
// The master drives button/mole inputs; the slave (scorer) drives score and status.
interface hit_scorer_if #(
  parameter int N_HOLES      = 4,
  parameter int SCORE_DIGITS = 2
);
  logic                      start;
  logic [N_HOLES-1:0]        btn;
  logic [N_HOLES-1:0]        mole;
  logic                      mole_new;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic [3:0]                miss_count;
  logic                      hit;
  logic                      miss;
  logic                      playing;
  logic                      game_over;

  // No valid/ready handshake: start, mole_new, hit and miss are single-cycle
  // pulses qualified by the posedge; btn and mole are levels sampled every cycle.
  modport master (
    output start, btn, mole, mole_new,
    input  score_bcd, miss_count, hit, miss, playing, game_over
  );

  modport slave (
    input  start, btn, mole, mole_new,
    output score_bcd, miss_count, hit, miss, playing, game_over
  );
endinterface

// File: rtl/hit_scorer.sv
// Whack-a-mole scoring stage: press edge detection, hit/miss classification,
// saturating BCD score, miss counter and the IDLE/PLAY/OVER game FSM.
module hit_scorer #(
  parameter int N_HOLES      = 4,
  parameter int SCORE_DIGITS = 2,
  parameter int MAX_MISSES   = 3
) (
  input  logic         clk,
  input  logic         rst,
  hit_scorer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int         SW    = 4 * SCORE_DIGITS;
  localparam logic [3:0] MAX_M = 4'(MAX_MISSES);

  state_t             state_q, state_d;
  logic               armed_q, armed_d;
  logic [N_HOLES-1:0] btn_prev_q;
  logic [SW-1:0]      score_q, score_d, score_inc;
  logic [3:0]         miss_cnt_q, miss_cnt_d;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic [N_HOLES-1:0] press;
  logic               is_hit, wrong, escape, carry, all9;

  assign press = bus.btn & ~btn_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      btn_prev_q <= '0;
      score_q    <= '0;
      miss_cnt_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      btn_prev_q <= bus.btn;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  // Ripple BCD increment; all9 flags the saturation point.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    all9      = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      all9 = all9 & (score_q[4*d +: 4] == 4'd9);
      if (carry) begin
        if (score_q[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    is_hit     = 1'b0;
    wrong      = 1'b0;
    escape     = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (bus.start) begin
          state_d    = PLAY;
          score_d    = '0;
          miss_cnt_d = '0;
          armed_d    = 1'b0;
        end
      end
      PLAY: begin
        if (bus.start) begin
          score_d    = '0;
          miss_cnt_d = '0;
          armed_d    = 1'b0;
        end else begin
          // Classification uses the armed value from before this cycle's update.
          is_hit = armed_q && ((press & bus.mole) != '0);
          wrong  = (press != '0) && !is_hit;
          escape = bus.mole_new && armed_q && !is_hit;
          if (is_hit) begin
            hit_d   = 1'b1;
            armed_d = 1'b0;
            if (!all9) score_d = score_inc;
          end
          if (bus.mole_new) armed_d = 1'b1;
          if (wrong || escape) begin
            miss_d     = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_q + 4'd1 == MAX_M) begin
              state_d = OVER;
              armed_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.score_bcd  = score_q;
  assign bus.miss_count = miss_cnt_q;
  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.playing    = (state_q == PLAY);
  assign bus.game_over  = (state_q == OVER);

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer: a driver pushes hand-computed expected outputs
// per cycle into a queue; a monitor pops and compares after every posedge.
module tb_hit_scorer;

  localparam int W = 16;

  logic clk;
  logic rst;

  hit_scorer_if #(.N_HOLES(4), .SCORE_DIGITS(2)) bus ();

  hit_scorer #(
    .N_HOLES(4), .SCORE_DIGITS(2), .MAX_MISSES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {hit, miss, score[7:0], miss_count[3:0], playing, game_over}
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           vec_id = 0;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step(input logic r, input logic s, input logic [3:0] b,
                      input logic [3:0] m, input logic mn,
                      input logic eh, input logic em, input logic [7:0] es,
                      input logic [3:0] emc, input logic ep, input logic eo);
    @(negedge clk);
    rst          = r;
    bus.start    = s;
    bus.btn      = b;
    bus.mole     = m;
    bus.mole_new = mn;
    exp_q.push_back({eh, em, es, emc, ep, eo});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  // Monitor
  initial begin
    logic [W-1:0] got, want;
    int id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        id   = id_q.pop_front();
        got  = {bus.hit, bus.miss, bus.score_bcd, bus.miss_count, bus.playing, bus.game_over};
        n_vec++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL vec %0d: got hit/miss/score/mc/play/over=%h required %h", id, got, want);
        end
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.btn = '0; bus.mole = '0; bus.mole_new = 1'b0;

    // reset state
    step(1, 0, 4'b0000, 4'b0000, 0,  0, 0, 8'h00, 4'd0, 0, 0);
    step(1, 0, 4'b0000, 4'b0000, 0,  0, 0, 8'h00, 4'd0, 0, 0);
    step(0, 0, 4'b0000, 4'b0000, 0,  0, 0, 8'h00, 4'd0, 0, 0);
    step(0, 1, 4'b0000, 4'b0000, 0,  0, 0, 8'h00, 4'd0, 1, 0);

    // basic hit, one-cycle pulse
    step(0, 0, 4'b0000, 4'b0010, 1,  0, 0, 8'h00, 4'd0, 1, 0);
    step(0, 0, 4'b0010, 4'b0010, 0,  1, 0, 8'h01, 4'd0, 1, 0);
    step(0, 0, 4'b0000, 4'b0010, 0,  0, 0, 8'h01, 4'd0, 1, 0);

    // wrong press, hit, then press on disarmed mole
    step(0, 0, 4'b0000, 4'b0100, 1,  0, 0, 8'h01, 4'd0, 1, 0);
    step(0, 0, 4'b0001, 4'b0100, 0,  0, 1, 8'h01, 4'd1, 1, 0);
    step(0, 0, 4'b0000, 4'b0100, 0,  0, 0, 8'h01, 4'd1, 1, 0);
    step(0, 0, 4'b0100, 4'b0100, 0,  1, 0, 8'h02, 4'd1, 1, 0);
    step(0, 0, 4'b0000, 4'b0100, 0,  0, 0, 8'h02, 4'd1, 1, 0);
    step(0, 0, 4'b0100, 4'b0100, 0,  0, 1, 8'h02, 4'd2, 1, 0);
    step(0, 0, 4'b0000, 4'b0100, 0,  0, 0, 8'h02, 4'd2, 1, 0);

    // restart in PLAY with a press the same cycle: suppressed, counters cleared
    step(0, 1, 4'b0100, 4'b0100, 0,  0, 0, 8'h00, 4'd0, 1, 0);
    step(0, 0, 4'b0000, 4'b0100, 0,  0, 0, 8'h00, 4'd0, 1, 0);

    // escape, escape+wrong counts once, third miss ends the game
    step(0, 0, 4'b0000, 4'b1000, 1,  0, 0, 8'h00, 4'd0, 1, 0);
    step(0, 0, 4'b0000, 4'b0001, 1,  0, 1, 8'h00, 4'd1, 1, 0);
    step(0, 0, 4'b0100, 4'b0010, 1,  0, 1, 8'h00, 4'd2, 1, 0);
    step(0, 0, 4'b0000, 4'b0010, 0,  0, 0, 8'h00, 4'd2, 1, 0);
    step(0, 0, 4'b1000, 4'b0010, 0,  0, 1, 8'h00, 4'd3, 0, 1);
    step(0, 0, 4'b0000, 4'b0010, 1,  0, 0, 8'h00, 4'd3, 0, 1);
    step(0, 0, 4'b0010, 4'b0010, 0,  0, 0, 8'h00, 4'd3, 0, 1);
    step(0, 0, 4'b0000, 4'b0010, 0,  0, 0, 8'h00, 4'd3, 0, 1);

    // start from OVER
    step(0, 1, 4'b0000, 4'b0010, 0,  0, 0, 8'h00, 4'd0, 1, 0);

    // rst mid-game with a would-be hit press
    step(0, 0, 4'b0000, 4'b0010, 1,  0, 0, 8'h00, 4'd0, 1, 0);
    step(1, 0, 4'b0010, 4'b0010, 0,  0, 0, 8'h00, 4'd0, 0, 0);
    step(0, 0, 4'b0010, 4'b0010, 0,  0, 0, 8'h00, 4'd0, 0, 0);

    // button held across start never counts until re-pressed
    step(0, 1, 4'b0010, 4'b0010, 0,  0, 0, 8'h00, 4'd0, 1, 0);
    step(0, 0, 4'b0010, 4'b0010, 1,  0, 0, 8'h00, 4'd0, 1, 0);
    step(0, 0, 4'b0010, 4'b0010, 0,  0, 0, 8'h00, 4'd0, 1, 0);
    step(0, 0, 4'b0000, 4'b0010, 0,  0, 0, 8'h00, 4'd0, 1, 0);
    // multi-button press containing the mole: single hit, no miss
    step(0, 0, 4'b0110, 4'b0010, 0,  1, 0, 8'h01, 4'd0, 1, 0);

    // hits 2..100: carries through 0x09->0x10, saturates at 0x99
    for (int i = 2; i <= 100; i++) begin
      step(0, 0, 4'b0000, 4'b0010, 1,  0, 0, to_bcd(i - 1), 4'd0, 1, 0);
      step(0, 0, 4'b0010, 4'b0010, 0,  1, 0, to_bcd(i > 99 ? 99 : i), 4'd0, 1, 0);
    end
    step(0, 0, 4'b0000, 4'b0010, 0,  0, 0, 8'h99, 4'd0, 1, 0);

    // drain with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
